wptr_handler: RTL and testbench
===============================

Name: wptr_handler

Overview:
- Write-domain pointer and flag controller for the dual-clock FIFO. It pairs with the read-side pointer handler.
- Advances the binary write address on accepted writes and publishes a registered Gray write pointer for synchronisation into the read domain.
- Generates full, almost-full and fill level from the read pointer after it has been synchronised into the write domain.

Parameters:
- PTR_WIDTH, 3, address bits of FIFO storage. Depth = 2^PTR_WIDTH. Pointers are PTR_WIDTH+1 bits. Legal range ≥ 1.
- AFULL_THRESH, 6, fill level at or above which wafull asserts. Legal range 1..2^PTR_WIDTH.

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  asynchronous active-low reset.
- winc  input  1  write request.
- wq2_rptr  input  PTR_WIDTH+1  Gray read pointer, already double-synchronised into wclk.
- wptr  output  PTR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchroniser.
- waddr  output  PTR_WIDTH+1  registered binary write address. Memory uses bits [PTR_WIDTH-1:0].
- wen  output  1  memory write strobe = winc & ~wfull (combinational).
- wfull  output  1  registered full flag.
- wafull  output  1  registered almost-full flag.
- wlevel  output  PTR_WIDTH+1  registered fill count, range 0..2^PTR_WIDTH.

Behaviour:
- Reset (async, wrst_n=0): waddr=0, wptr=0, wfull=0, wafull=0, wlevel=0. Outputs take these values immediately, independent of wclk. Release is synchronous to the next wclk edge.
- Next address: waddr_next = waddr + wen. Addition is modulo 2^(PTR_WIDTH+1) and wraps from all-ones to 0 with no special handling.
- Next Gray pointer: wgray_next = waddr_next ^ (waddr_next >> 1).
- Every wclk edge: waddr <= waddr_next and wptr <= wgray_next. wptr is a flop output, so it is glitch-free. Only one bit changes per accepted write.
- Full detection uses the next pointer, so there is no lag. The full condition is: wgray_next == {~wq2_rptr[PTR_WIDTH:PTR_WIDTH-1], wq2_rptr[PTR_WIDTH-2:0]}.
  - When PTR_WIDTH=1 the compare is wgray_next == ~wq2_rptr.
  - wfull <= full condition, every edge.
  - wfull asserts on the same edge that writes the last free slot.
- Write while full: wen=0. waddr, wptr and wlevel are unchanged by that request. No error is signalled (see the optional feature).
- Read-pointer conversion: rbin is the Gray-to-binary conversion of wq2_rptr (prefix XOR from the MSB down), combinational.
- Level: lvl_next = waddr_next − rbin, modulo 2^(PTR_WIDTH+1).
  - wlevel <= lvl_next.
  - wafull <= (lvl_next ≥ AFULL_THRESH).
  - wfull equals (lvl_next == 2^PTR_WIDTH) by construction.
- Simultaneous winc and wq2_rptr change: both are used in the same cycle's next-state computation, so flags reflect the new write and the new read pointer together.
- Pessimism: wq2_rptr lags the true read pointer by ≥2 wclk. wfull, wafull and wlevel may therefore overstate occupancy but never understate it. Full deasserts at least one wclk after wq2_rptr advances.
- No state machine. State is the waddr, wptr and flag registers only.

Optional Feature:
- Macro: WPTR_OVERFLOW_EN.
- When defined:
  - Adds output port woverflow (1 bit).
  - woverflow is a sticky flag: woverflow <= woverflow | (winc & wfull).
  - It is cleared only by wrst_n (reset value 0).
  - It is set on the edge after the rejected write.
- When undefined: the port and its register are absent. Rejected writes are silently dropped. All other behaviour is identical.

Test Plan (PTR_WIDTH=3, AFULL_THRESH=6):
1. Assert wrst_n=0 mid-clock with waddr=5 → waddr, wptr, wlevel, wfull and wafull all go to 0 before the next wclk. Release, then one write → waddr=1, wptr=4'b0001, wlevel=1.
2. Hold wq2_rptr=0 and issue 8 consecutive winc:
   - After the 6th write: wafull=1, wlevel=6.
   - On the 8th edge: wfull=1, waddr=4'b1000, wptr=4'b1100, wlevel=8.
   - A 9th winc gives wen=0 and no change.
3. From the full state, set wq2_rptr=4'b0001 → next edge: wfull=0, wlevel=7, wafull=1. Set wq2_rptr=4'b0011 (read pointer 2) → wlevel=6, wafull=1. Set wq2_rptr=4'b0010 (read pointer 3) → wlevel=5, wafull=0.
4. Wrap-around: start at waddr=15 (wptr=4'b1000) with wq2_rptr=gray(12)=4'b1010, then write once → waddr=0, wptr=4'b0000, wlevel=4, wfull=0.
5. Simultaneous write and pointer move: start at waddr=7, wq2_rptr=0, then winc=1 together with wq2_rptr=4'b0001 → waddr=8, wlevel=7, wfull=0.
6. With WPTR_OVERFLOW_EN defined:
   - Fill to full, then 1 extra winc → woverflow=1 on the following edge, waddr unchanged at 8.
   - Drain via wq2_rptr → woverflow stays 1 until wrst_n=0.
   - Build without the macro → the port does not exist.

Source files
------------

// File: rtl/wptr_handler.sv
// -----------------------------------------------------------------------------
// wptr_handler
// Write-domain pointer and flag controller for the dual-clock FIFO.
//
// The block keeps the binary write address and publishes a registered Gray
// write pointer for the read-domain synchroniser. It derives full, almost-full
// and fill level from the read pointer that has already been synchronised into
// wclk. Every flag is computed from the next-state pointer, so it is correct on
// the same edge that performs the write.
//
// Optional feature: define WPTR_OVERFLOW_EN to add the sticky woverflow output.
// That output is set by any write request that arrives while the FIFO is full.
// -----------------------------------------------------------------------------
module wptr_handler #(
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [PTR_WIDTH:0]   wq2_rptr,
  output logic [PTR_WIDTH:0]   wptr,
  output logic [PTR_WIDTH:0]   waddr,
  output logic                 wen,
  output logic                 wfull,
  output logic                 wafull,
  output logic [PTR_WIDTH:0]   wlevel
`ifdef WPTR_OVERFLOW_EN
  ,
  output logic                 woverflow
`endif
);

  // XOR-ing the synchronised read pointer with this mask inverts its two MSBs,
  // which is the Gray encoding of "read pointer plus depth". With
  // PTR_WIDTH == 1 the mask is all ones, so the compare becomes ~wq2_rptr.
  localparam logic [PTR_WIDTH:0] FULL_MASK =
    {(PTR_WIDTH+1){1'b1}} << (PTR_WIDTH-1);
  localparam logic [PTR_WIDTH:0] AFULL_LVL = (PTR_WIDTH+1)'(AFULL_THRESH);

  // Gray to binary conversion: prefix XOR from the MSB down.
  function automatic logic [PTR_WIDTH:0] gray2bin_f(input logic [PTR_WIDTH:0] g);
    logic [PTR_WIDTH:0] b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray conversion.
  function automatic logic [PTR_WIDTH:0] bin2gray_f(input logic [PTR_WIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PTR_WIDTH:0] waddr_r;
  logic [PTR_WIDTH:0] wptr_r;
  logic [PTR_WIDTH:0] wlevel_r;
  logic               wfull_r;
  logic               wafull_r;

  logic               wen_s;
  logic [PTR_WIDTH:0] waddr_next_s;
  logic [PTR_WIDTH:0] wgray_next_s;
  logic [PTR_WIDTH:0] rbin_s;
  logic [PTR_WIDTH:0] lvl_next_s;
  logic               full_next_s;
  logic               afull_next_s;

  // Next-state pointers, level and flag conditions for the coming wclk edge.
  always_comb begin
    wen_s        = winc & ~wfull_r;
    waddr_next_s = waddr_r + {{PTR_WIDTH{1'b0}}, wen_s};
    wgray_next_s = bin2gray_f(waddr_next_s);
    rbin_s       = gray2bin_f(wq2_rptr);
    lvl_next_s   = waddr_next_s - rbin_s;
    full_next_s  = (wgray_next_s == (wq2_rptr ^ FULL_MASK));
    afull_next_s = (lvl_next_s >= AFULL_LVL);
  end

  // Pointer, level and flag registers. The reset is asynchronous.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      waddr_r  <= '0;
      wptr_r   <= '0;
      wlevel_r <= '0;
      wfull_r  <= 1'b0;
      wafull_r <= 1'b0;
    end else begin
      waddr_r  <= waddr_next_s;
      wptr_r   <= wgray_next_s;
      wlevel_r <= lvl_next_s;
      wfull_r  <= full_next_s;
      wafull_r <= afull_next_s;
    end
  end

`ifdef WPTR_OVERFLOW_EN
  logic woverflow_r;

  // Sticky overflow flag. It is set after a write request arrives while full
  // and is cleared only by reset.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      woverflow_r <= 1'b0;
    end else begin
      woverflow_r <= woverflow_r | (winc & wfull_r);
    end
  end

  assign woverflow = woverflow_r;
`endif

  assign wen    = wen_s;
  assign waddr  = waddr_r;
  assign wptr   = wptr_r;
  assign wlevel = wlevel_r;
  assign wfull  = wfull_r;
  assign wafull = wafull_r;

endmodule

// File: tb/tb_wptr_handler.sv
// -----------------------------------------------------------------------------
// tb_wptr_handler
// Directed, table-driven bench for wptr_handler (PTR_WIDTH=3, AFULL_THRESH=6).
// If WPTR_OVERFLOW_EN is defined, the bench also checks the sticky overflow
// flag.
// -----------------------------------------------------------------------------
module tb_wptr_handler;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [3:0] wq2_rptr;
  logic [3:0] wptr;
  logic [3:0] waddr;
  logic       wen;
  logic       wfull;
  logic       wafull;
  logic [3:0] wlevel;
`ifdef WPTR_OVERFLOW_EN
  logic       woverflow;
`endif

  int n_tests;
  int n_fail;

  wptr_handler #(
    .PTR_WIDTH   (3),
    .AFULL_THRESH(6)
  ) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
    .wptr     (wptr),
    .waddr    (waddr),
    .wen      (wen),
    .wfull    (wfull),
    .wafull   (wafull),
    .wlevel   (wlevel)
`ifdef WPTR_OVERFLOW_EN
    ,
    .woverflow(woverflow)
`endif
  );

  // Free-running write clock with a 10 ns period.
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic [3:0] rptr;
    logic       e_wen;
    logic [3:0] e_waddr;
    logic [3:0] e_wptr;
    logic [3:0] e_lvl;
    logic       e_full;
    logic       e_afull;
  } vec_t;

  vec_t vecs [30];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_v(input int i, input logic wi, input logic [3:0] r,
                       input logic ew, input logic [3:0] ea, input logic [3:0] ep,
                       input logic [3:0] el, input logic ef, input logic eaf);
    vecs[i].winc    = wi;
    vecs[i].rptr    = r;
    vecs[i].e_wen   = ew;
    vecs[i].e_waddr = ea;
    vecs[i].e_wptr  = ep;
    vecs[i].e_lvl   = el;
    vecs[i].e_full  = ef;
    vecs[i].e_afull = eaf;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " waddr"},  int'(waddr),  0);
    chk({tag, " wptr"},   int'(wptr),   0);
    chk({tag, " wlevel"}, int'(wlevel), 0);
    chk({tag, " wfull"},  int'(wfull),  0);
    chk({tag, " wafull"}, int'(wafull), 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //      idx winc rptr     wen  waddr  wptr     lvl  full  afull
    // Fill from empty with the read pointer held at 0.
    set_v( 0, 1'b1, 4'b0000, 1'b1, 4'd1,  4'b0001, 4'd1, 1'b0, 1'b0);
    set_v( 1, 1'b1, 4'b0000, 1'b1, 4'd2,  4'b0011, 4'd2, 1'b0, 1'b0);
    set_v( 2, 1'b1, 4'b0000, 1'b1, 4'd3,  4'b0010, 4'd3, 1'b0, 1'b0);
    set_v( 3, 1'b1, 4'b0000, 1'b1, 4'd4,  4'b0110, 4'd4, 1'b0, 1'b0);
    set_v( 4, 1'b1, 4'b0000, 1'b1, 4'd5,  4'b0111, 4'd5, 1'b0, 1'b0);
    set_v( 5, 1'b1, 4'b0000, 1'b1, 4'd6,  4'b0101, 4'd6, 1'b0, 1'b1);
    set_v( 6, 1'b1, 4'b0000, 1'b1, 4'd7,  4'b0100, 4'd7, 1'b0, 1'b1);
    set_v( 7, 1'b1, 4'b0000, 1'b1, 4'd8,  4'b1100, 4'd8, 1'b1, 1'b1);
    // A write request while full is rejected.
    set_v( 8, 1'b1, 4'b0000, 1'b0, 4'd8,  4'b1100, 4'd8, 1'b1, 1'b1);
    // Drain through the read pointer: rptr=1, 2, 3.
    set_v( 9, 1'b0, 4'b0001, 1'b0, 4'd8,  4'b1100, 4'd7, 1'b0, 1'b1);
    set_v(10, 1'b0, 4'b0011, 1'b0, 4'd8,  4'b1100, 4'd6, 1'b0, 1'b1);
    set_v(11, 1'b0, 4'b0010, 1'b0, 4'd8,  4'b1100, 4'd5, 1'b0, 1'b0);
    // Move the write address to 15 with the read pointer at 7, then at 12.
    set_v(12, 1'b1, 4'b0100, 1'b1, 4'd9,  4'b1101, 4'd2, 1'b0, 1'b0);
    set_v(13, 1'b1, 4'b0100, 1'b1, 4'd10, 4'b1111, 4'd3, 1'b0, 1'b0);
    set_v(14, 1'b1, 4'b0100, 1'b1, 4'd11, 4'b1110, 4'd4, 1'b0, 1'b0);
    set_v(15, 1'b1, 4'b0100, 1'b1, 4'd12, 4'b1010, 4'd5, 1'b0, 1'b0);
    set_v(16, 1'b1, 4'b1010, 1'b1, 4'd13, 4'b1011, 4'd1, 1'b0, 1'b0);
    set_v(17, 1'b1, 4'b1010, 1'b1, 4'd14, 4'b1001, 4'd2, 1'b0, 1'b0);
    set_v(18, 1'b1, 4'b1010, 1'b1, 4'd15, 4'b1000, 4'd3, 1'b0, 1'b0);
    // Wrap-around from 15 to 0 with the read pointer at 12.
    set_v(19, 1'b1, 4'b1010, 1'b1, 4'd0,  4'b0000, 4'd4, 1'b0, 1'b0);
    // Refill from 0 up to 7 with the read pointer at 0.
    set_v(20, 1'b1, 4'b0000, 1'b1, 4'd1,  4'b0001, 4'd1, 1'b0, 1'b0);
    set_v(21, 1'b1, 4'b0000, 1'b1, 4'd2,  4'b0011, 4'd2, 1'b0, 1'b0);
    set_v(22, 1'b1, 4'b0000, 1'b1, 4'd3,  4'b0010, 4'd3, 1'b0, 1'b0);
    set_v(23, 1'b1, 4'b0000, 1'b1, 4'd4,  4'b0110, 4'd4, 1'b0, 1'b0);
    set_v(24, 1'b1, 4'b0000, 1'b1, 4'd5,  4'b0111, 4'd5, 1'b0, 1'b0);
    set_v(25, 1'b1, 4'b0000, 1'b1, 4'd6,  4'b0101, 4'd6, 1'b0, 1'b1);
    set_v(26, 1'b1, 4'b0000, 1'b1, 4'd7,  4'b0100, 4'd7, 1'b0, 1'b1);
    // A write and a read-pointer move in the same cycle.
    set_v(27, 1'b1, 4'b0001, 1'b1, 4'd8,  4'b1100, 4'd7, 1'b0, 1'b1);
    // Full with a nonzero read pointer, then a rejected write.
    set_v(28, 1'b1, 4'b0001, 1'b1, 4'd9,  4'b1101, 4'd8, 1'b1, 1'b1);
    set_v(29, 1'b1, 4'b0001, 1'b0, 4'd9,  4'b1101, 4'd8, 1'b1, 1'b1);

    // Power-on reset.
    wrst_n   = 1'b0;
    winc     = 1'b0;
    wq2_rptr = 4'b0000;
    repeat (2) @(posedge wclk);
    #1;
    chk_zero("por");
`ifdef WPTR_OVERFLOW_EN
    chk("por woverflow", int'(woverflow), 0);
`endif
    @(negedge wclk);
    wrst_n = 1'b1;

    // Reach waddr=5, then assert reset mid-clock.
    winc = 1'b1;
    repeat (5) begin
      @(posedge wclk);
      #1;
    end
    chk("pre-reset waddr", int'(waddr), 5);
    @(negedge wclk);
    winc = 1'b0;
    #2;
    wrst_n = 1'b0;
    #1;
    // Sampled before the next rising edge, so the reset has acted asynchronously.
    chk_zero("async rst");
    @(negedge wclk);
    wrst_n = 1'b1;

    // Apply the vector table.
    for (int i = 0; i < 30; i++) begin
      @(negedge wclk);
      winc     = vecs[i].winc;
      wq2_rptr = vecs[i].rptr;
      #1;
      chk($sformatf("v%0d wen", i), int'(wen), int'(vecs[i].e_wen));
      @(posedge wclk);
      #1;
      chk($sformatf("v%0d waddr", i),  int'(waddr),  int'(vecs[i].e_waddr));
      chk($sformatf("v%0d wptr", i),   int'(wptr),   int'(vecs[i].e_wptr));
      chk($sformatf("v%0d wlevel", i), int'(wlevel), int'(vecs[i].e_lvl));
      chk($sformatf("v%0d wfull", i),  int'(wfull),  int'(vecs[i].e_full));
      chk($sformatf("v%0d wafull", i), int'(wafull), int'(vecs[i].e_afull));
    end

`ifdef WPTR_OVERFLOW_EN
    // Earlier rejected writes must have set the sticky flag.
    chk("ovf set", int'(woverflow), 1);
    chk("ovf waddr held", int'(waddr), 9);
    // Drain completely with read pointer 9 (gray 1101). The flag stays set.
    @(negedge wclk);
    winc     = 1'b0;
    wq2_rptr = 4'b1101;
    @(posedge wclk);
    #1;
    chk("ovf drain wlevel", int'(wlevel), 0);
    chk("ovf drain wfull", int'(wfull), 0);
    chk("ovf sticky", int'(woverflow), 1);
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    chk("ovf cleared by rst", int'(woverflow), 0);
    @(negedge wclk);
    wrst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
